// File: rtl/vram_dma_m_pkg.sv
// Shared GPU definitions for the VRAM write-side DMA: state encoding,
// VRAM address width and region base addresses.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

package vram_dma_m_pkg;

    localparam int VRAM_AW = `VRAM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } vram_dma_state_t;

    localparam logic [VRAM_AW-1:0] PMF_BASE = 12'h000;
    localparam logic [VRAM_AW-1:0] OBM_BASE = 12'h800;

endpackage

// File: rtl/vram_dma_m.sv
// Copies a byte block from CPU-side memory into VRAM one byte at a time,
// writing only while the video timing window is open.
module vram_dma_m
    import vram_dma_m_pkg::*;
#(
    parameter int SRC_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH      = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SRC_ADDR_WIDTH-1:0] src_base,
    input  logic [VRAM_AW-1:0]        dst_base,
    input  logic [LEN_WIDTH-1:0]      length,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      src_rd_en,
    output logic [SRC_ADDR_WIDTH-1:0] src_addr,
    input  logic                      src_gnt,
    input  logic [7:0]                src_rd_data,
    input  logic                      writable,
    output logic [7:0]                vram_data,
    output logic [VRAM_AW-1:0]        vram_address,
    output logic                      vram_write_enable
);

    vram_dma_state_t           r_state;
    logic [SRC_ADDR_WIDTH-1:0] r_src;
    logic [VRAM_AW-1:0]        r_dst;
    logic [LEN_WIDTH-1:0]      r_rem;
    logic [7:0]                r_buf;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_src_rd_en;

    vram_dma_state_t           w_state_nxt;
    logic [SRC_ADDR_WIDTH-1:0] w_src_nxt;
    logic [VRAM_AW-1:0]        w_dst_nxt;
    logic [LEN_WIDTH-1:0]      w_rem_nxt;
    logic [7:0]                w_buf_nxt;
    logic                      w_done_nxt;

    // Next-state, pointer and buffer update; abort outranks grant and write.
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_rem_nxt   = r_rem;
        w_buf_nxt   = r_buf;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (start) begin
                    if (length != {LEN_WIDTH{1'b0}}) begin
                        w_src_nxt   = src_base;
                        w_dst_nxt   = dst_base;
                        w_rem_nxt   = length;
                        w_state_nxt = REQ;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (src_gnt) begin
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            DATA: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_buf_nxt   = src_rd_data;
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (writable) begin
                    w_src_nxt = r_src + SRC_ADDR_WIDTH'(1);
                    w_dst_nxt = r_dst + VRAM_AW'(1);
                    w_rem_nxt = r_rem - LEN_WIDTH'(1);
                    if (r_rem == LEN_WIDTH'(1)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end else begin
                    w_state_nxt = WRITE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters, buffer and the registered status/request outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_src       <= {SRC_ADDR_WIDTH{1'b0}};
            r_dst       <= {VRAM_AW{1'b0}};
            r_rem       <= {LEN_WIDTH{1'b0}};
            r_buf       <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_src_rd_en <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_src       <= w_src_nxt;
            r_dst       <= w_dst_nxt;
            r_rem       <= w_rem_nxt;
            r_buf       <= w_buf_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= w_done_nxt;
            r_src_rd_en <= (w_state_nxt == REQ);
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign src_rd_en    = r_src_rd_en;
    assign src_addr     = r_src;
    assign vram_data    = r_buf;
    assign vram_address = r_dst;
    // Gated by abort so a cancelled transfer never lands a final byte.
    assign vram_write_enable = (r_state == WRITE) && writable && !abort;

endmodule

// File: tb/tb_vram_dma_m.sv
// Self-checking bench for vram_dma_m: directed scenarios plus randomized
// traffic checked against a queue-based model of the expected VRAM writes.
module tb_vram_dma_m;
    import vram_dma_m_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, abort, src_gnt, writable;
    logic [15:0]       src_base;
    logic [11:0]       dst_base;
    logic [9:0]        length;
    logic              busy, done, src_rd_en, vram_write_enable;
    logic [15:0]       src_addr;
    logic [7:0]        src_rd_data, vram_data;
    logic [11:0]       vram_address;

    vram_dma_m dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base),
        .dst_base(dst_base), .length(length), .abort(abort),
        .busy(busy), .done(done), .src_rd_en(src_rd_en), .src_addr(src_addr),
        .src_gnt(src_gnt), .src_rd_data(src_rd_data), .writable(writable),
        .vram_data(vram_data), .vram_address(vram_address),
        .vram_write_enable(vram_write_enable)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    // Source memory: data arrives the cycle after a grant, garbage otherwise.
    always @(posedge clk) begin
        if (src_rd_en && src_gnt) src_rd_data <= mem[src_addr];
        else                      src_rd_data <= 8'($urandom);
    end

    typedef struct { logic [15:0] src; logic [11:0] dst; logic [7:0] data; } wr_t;
    wr_t         q[$];
    logic [11:0] addr_log[$];
    int          n_checks = 0, n_errors = 0;
    int          writes_seen = 0, done_seen = 0;
    bit          model_active = 0, exp_busy = 0, exp_done = 0, len0_now = 0;
    bit          rand_mode = 0;
    logic        nx_start = 0, nx_abort = 0, nx_gnt = 1, nx_wr = 1;
    logic [15:0] nx_src = 0;
    logic [11:0] nx_dst = 0;
    logic [9:0]  nx_len = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        bit dn;
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        check("done", {31'd0, done}, {31'd0, exp_done});
        if (done) done_seen++;
        dn = len0_now;
        if (vram_write_enable) begin
            writes_seen++;
            addr_log.push_back(vram_address);
            check("write_expected", q.size(), (q.size() == 0) ? 1 : q.size());
            if (q.size() != 0) begin
                check("vram_address", {20'd0, vram_address}, {20'd0, q[0].dst});
                check("vram_data", {24'd0, vram_data}, {24'd0, q[0].data});
                void'(q.pop_front());
                if (q.size() == 0) begin
                    model_active = 0;
                    dn = 1;
                end
            end
        end
        if (src_rd_en && model_active && q.size() != 0)
            check("src_addr", {16'd0, src_addr}, {16'd0, q[0].src});
        exp_done = dn;
        exp_busy = model_active;
        len0_now = 0;
    endtask

    // One clock: apply inputs at the falling edge, update the model, sample.
    task automatic cycle();
        wr_t e;
        @(negedge clk);
        start = nx_start; abort = nx_abort;
        src_base = nx_src; dst_base = nx_dst; length = nx_len;
        if (rand_mode) begin
            src_gnt  = ($urandom_range(0, 2) != 0);
            writable = ($urandom_range(0, 3) != 0);
        end else begin
            src_gnt = nx_gnt; writable = nx_wr;
        end
        if (rst) begin
            if (abort && model_active) begin
                q.delete();
                model_active = 0;
            end else if (start && !abort && !model_active) begin
                if (length == 10'd0) len0_now = 1;
                else begin
                    for (int i = 0; i < int'(length); i++) begin
                        e.src  = src_base + 16'(i);
                        e.dst  = dst_base + 12'(i);
                        e.data = mem[e.src];
                        q.push_back(e);
                    end
                    model_active = 1;
                end
            end
        end
        #1;
        monitor();
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && model_active; k++) cycle();
        check("drain_budget", {31'd0, model_active}, 32'd0);
        cycle();
    endtask

    task automatic go(input logic [15:0] s, input logic [11:0] d, input logic [9:0] l);
        nx_src = s; nx_dst = d; nx_len = l; nx_start = 1;
        cycle();
        nx_start = 0;
    endtask

    initial begin
        int w0, d0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b0; start = 0; abort = 0; src_gnt = 0; writable = 0;
        src_base = 0; dst_base = 0; length = 0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outs", {src_rd_en, done, vram_write_enable, src_addr, vram_data},
              32'd0);
        check("rst_vaddr", {20'd0, vram_address}, 32'd0);
        rst = 1'b1;
        cycle();

        // 1: four bytes, full speed; start accepted alongside done.
        go(16'h0200, 12'h800, 10'd4);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            check("t1_we_cadence", {31'd0, vram_write_enable}, (i % 3 == 0) ? 32'd1 : 32'd0);
        end
        go(16'h0210, 12'h810, 10'd1);
        drain(50);

        // 2: write window closed for 11 cycles in WRITE.
        nx_wr = 0;
        go(16'h1234, 12'h123, 10'd2);
        for (int i = 1; i <= 13; i++) begin
            cycle();
            check("t2_no_we", {31'd0, vram_write_enable}, 32'd0);
            if (i >= 3) begin
                check("t2_addr_hold", {20'd0, vram_address}, 32'h123);
                check("t2_data_hold", {24'd0, vram_data}, {24'd0, mem[16'h1234]});
            end
        end
        nx_wr = 1;
        drain(50);

        // 3: zero length.
        go(16'h0400, 12'h000, 10'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t3_no_rd", {31'd0, src_rd_en}, 32'd0);
            check("t3_no_we", {31'd0, vram_write_enable}, 32'd0);
        end

        // 4: destination wrap.
        addr_log.delete();
        go(16'hFFFE, 12'hFFE, 10'd4);
        drain(50);
        check("t4_nwr", addr_log.size(), 32'd4);
        if (addr_log.size() == 4) begin
            check("t4_a0", {20'd0, addr_log[0]}, 32'hFFE);
            check("t4_a1", {20'd0, addr_log[1]}, 32'hFFF);
            check("t4_a2", {20'd0, addr_log[2]}, 32'h000);
            check("t4_a3", {20'd0, addr_log[3]}, 32'h001);
        end

        // 5: grant withheld for 5 cycles.
        nx_gnt = 0;
        go(16'h5555, 12'h055, 10'd1);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check("t5_rd_en", {31'd0, src_rd_en}, 32'd1);
            check("t5_src_addr", {16'd0, src_addr}, 32'h5555);
        end
        nx_gnt = 1;
        drain(50);

        // 6a: abort after two of six bytes.
        w0 = writes_seen; d0 = done_seen;
        go(16'h0700, 12'h300, 10'd6);
        for (int k = 0; k < 100 && (writes_seen - w0) < 2; k++) cycle();
        for (int k = 0; k < 10 && !src_rd_en; k++) cycle();
        nx_abort = 1;
        cycle();
        nx_abort = 0;
        for (int i = 0; i < 8; i++) cycle();
        check("t6_two_writes", writes_seen - w0, 32'd2);
        check("t6_no_done", done_seen - d0, 32'd0);

        // 6b: start while busy is ignored.
        w0 = writes_seen;
        go(16'h0900, 12'h100, 10'd3);
        for (int i = 0; i < 4; i++) cycle();
        go(16'hA000, 12'hA00, 10'd5);
        drain(50);
        check("t6_ignored_start", writes_seen - w0, 32'd3);

        // 6c: reset mid-transfer.
        go(16'h0B00, 12'h200, 10'd5);
        for (int i = 0; i < 5; i++) cycle();
        #2 rst = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_outs", {src_rd_en, done, vram_write_enable, src_addr, vram_data},
              32'd0);
        check("t6_rst_vaddr", {20'd0, vram_address}, 32'd0);
        q.delete(); model_active = 0; exp_busy = 0; exp_done = 0;
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic: stalls, aborts, starts while busy, wrap.
        rand_mode = 1;
        for (int c = 0; c < 4000; c++) begin
            nx_start = 0;
            nx_abort = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0 || (model_active && $urandom_range(0, 30) == 0)) begin
                nx_start = 1;
                nx_src = 16'($urandom);
                nx_dst = ($urandom_range(0, 3) == 0) ? 12'(12'hFF8 + 12'($urandom_range(0, 7)))
                                                     : 12'($urandom);
                nx_len = 10'($urandom_range(0, 12));
            end
            cycle();
        end
        nx_start = 0; nx_abort = 0;
        drain(2000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
